// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the raster timing generator:
//   - axis_timing_t : active/porch/sync/polarity set for one axis
//   - presets for 640x480@60 and 1280x720@60
//   - axis_total()  : total count of an axis from its four segments
//   - DEF_H / DEF_V : default preset used by video_timing_gen parameters
// -----------------------------------------------------------------------------
package video_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;     // sync active level (0 = active-low)
  } axis_timing_t;

  typedef enum logic [0:0] {
    MODE_640X480,
    MODE_1280X720
  } timing_mode_e;

  localparam axis_timing_t H_640X480  = '{active: 640,  fp: 16,  sync: 96, bp: 48,  pol: 1'b0};
  localparam axis_timing_t V_640X480  = '{active: 480,  fp: 10,  sync: 2,  bp: 33,  pol: 1'b0};
  localparam axis_timing_t H_1280X720 = '{active: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1};
  localparam axis_timing_t V_1280X720 = '{active: 720,  fp: 5,   sync: 5,  bp: 20,  pol: 1'b1};

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic axis_timing_t h_preset(input timing_mode_e mode);
    return (mode == MODE_1280X720) ? H_1280X720 : H_640X480;
  endfunction

  function automatic axis_timing_t v_preset(input timing_mode_e mode);
    return (mode == MODE_1280X720) ? V_1280X720 : V_640X480;
  endfunction

  localparam axis_timing_t DEF_H = h_preset(MODE_640X480);
  localparam axis_timing_t DEF_V = v_preset(MODE_640X480);

endpackage

// File: rtl/vtg_axis_counter.sv
// -----------------------------------------------------------------------------
// vtg_axis_counter
// One axis (horizontal or vertical) of the raster timing generator.
// The count advances when step && wrap_en, wrapping from TOTAL-1 to 0.
// All flags are registered from the next count, so they line up with count.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   step           pixel enable
//   wrap_en        carry-in: axis may advance this cycle (1 for horizontal,
//                  "horizontal at last column" for vertical)
//   count [W]      current position, reset value TOTAL-1
//   active         count < ACTIVE
//   sync           sync output at level POL while inside the sync window
//   at_last        count == TOTAL-1
//   entered_zero   one-cycle pulse after the edge that moved count to 0
// -----------------------------------------------------------------------------
import video_timing_pkg::*;

module vtg_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         wrap_en,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync,
  output logic         at_last,
  output logic         entered_zero
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

  if (FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_segment
    $error("vtg_axis_counter: porch and sync widths must be >= 1");
  end
  if (64'(TOTAL) > (64'd1 << W)) begin : g_bad_width
    $error("vtg_axis_counter: axis total does not fit in W bits");
  end

  logic         advance;
  logic [W-1:0] count_next;
  logic         in_sync_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    advance    = step & wrap_en;
    count_next = count;
    if (advance) begin
      count_next = (count == LAST) ? '0 : count + W'(1);
    end
    in_sync_next = (32'(count_next) >= SYNC_START) && (32'(count_next) < SYNC_END);
  end

  // Reset values describe position TOTAL-1, which lies in the back porch:
  // inactive, not in sync, at last.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= LAST;
      active       <= 1'b0;
      sync         <= ~POL;
      at_last      <= 1'b1;
      entered_zero <= 1'b0;
    end else begin
      count        <= count_next;
      active       <= 32'(count_next) < ACTIVE;
      sync         <= in_sync_next ? POL : ~POL;
      at_last      <= (count_next == LAST);
      // Cleared on any edge that does not move the axis onto zero.
      entered_zero <= advance && (count_next == '0);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster timing generator. Advances one pixel per clk edge with
// en=1; produces coordinates, syncs, data-enable, line/frame/vblank strobes and
// a completed-frame counter. All outputs describe the pixel (sx,sy).
//
// Optional feature macro: VTG_ANIM_TICK_EN
//   defined   : adds parameter ANIM_DIV; anim_tick pulses with every
//               ANIM_DIV-th vblank (first on the ANIM_DIV-th after reset)
//   undefined : anim_tick tied to 0
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               pixel enable
//   sx, sy [CORDW]   current column / line
//   hsync, vsync     syncs at polarity HS_POL / VS_POL
//   de               inside active area
//   line             pulse on entering sx==0
//   frame            pulse on entering (0,0)
//   vblank           pulse on entering (0,V_ACTIVE)
//   frame_cnt        completed-frame count, wraps
//   anim_tick        divided vblank pulse (see macro above)
// -----------------------------------------------------------------------------
import video_timing_pkg::*;

module video_timing_gen #(
  parameter int unsigned H_ACTIVE = DEF_H.active,
  parameter int unsigned H_FP     = DEF_H.fp,
  parameter int unsigned H_SYNC   = DEF_H.sync,
  parameter int unsigned H_BP     = DEF_H.bp,
  parameter int unsigned V_ACTIVE = DEF_V.active,
  parameter int unsigned V_FP     = DEF_V.fp,
  parameter int unsigned V_SYNC   = DEF_V.sync,
  parameter int unsigned V_BP     = DEF_V.bp,
  parameter bit          HS_POL   = DEF_H.pol,
  parameter bit          VS_POL   = DEF_V.pol,
  parameter int unsigned CORDW    = 10,
  parameter int unsigned FRAME_W  = 16
`ifdef VTG_ANIM_TICK_EN
  ,
  parameter int unsigned ANIM_DIV = 1
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CORDW-1:0]   sx,
  output logic [CORDW-1:0]   sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line,
  output logic               frame,
  output logic               vblank,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               anim_tick
);

  logic h_active, h_last, h_zero;
  logic v_active, v_last, v_zero;
  logic frame_wrap;
  logic vblank_next;
  logic started;

  vtg_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (CORDW)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (en),
    .wrap_en      (1'b1),
    .count        (sx),
    .active       (h_active),
    .sync         (hsync),
    .at_last      (h_last),
    .entered_zero (h_zero)
  );

  // The vertical axis only moves on the edge that wraps the horizontal one,
  // so vsync and the vertical flags change exactly at sx==0.
  vtg_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (CORDW)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (en),
    .wrap_en      (h_last),
    .count        (sy),
    .active       (v_active),
    .sync         (vsync),
    .at_last      (v_last),
    .entered_zero (v_zero)
  );

  // Both operands are registered on the same edge, so these stay aligned
  // with sx/sy. v_zero can only pulse on a horizontal wrap.
  assign de    = h_active & v_active;
  assign line  = h_zero;
  assign frame = h_zero & v_zero;

  assign frame_wrap  = en & h_last & v_last;
  assign vblank_next = en & h_last & (sy == CORDW'(V_ACTIVE - 1));

  // The landing on (0,0) right after reset is not a completed frame; started
  // records that the first landing has happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      started   <= 1'b0;
      vblank    <= 1'b0;
    end else begin
      vblank <= vblank_next;
      if (frame_wrap) begin
        started <= 1'b1;
        if (started) begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

`ifdef VTG_ANIM_TICK_EN
  localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  if (ANIM_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: ANIM_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt;

  // div_cnt counts vblanks seen since the last tick; the tick rides on the
  // same edge that raises vblank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      anim_tick <= 1'b0;
    end else begin
      anim_tick <= 1'b0;
      if (vblank_next) begin
        if (32'(div_cnt) == ANIM_DIV - 1) begin
          div_cnt   <= '0;
          anim_tick <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end
`else
  assign anim_tick = 1'b0;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator, successor to the fixed 640x480 timing block. Produces pixel coordinates, hsync/vsync with configurable polarity, data-enable, and line/frame/vblank strobes plus a frame counter. Feeds the shader pipeline (sx/sy/de) and the TMDS encoders (hsync/vsync/de) in the HDMI top. Advances only on cycles where the pixel-enable input is high, so it can run from a faster system clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CORDW, 10, coordinate width
FRAME_W, 16, frame counter width

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  pixel enable; state advances only when high
sx  out  CORDW  current column, 0..H_TOTAL-1
sy  out  CORDW  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  high inside the active area
line  out  1  one-cycle pulse on entering sx==0
frame  out  1  one-cycle pulse on entering (0,0)
vblank  out  1  one-cycle pulse on entering (0,V_ACTIVE)
frame_cnt  out  FRAME_W  completed-frame count, wraps
anim_tick  out  1  see Optional Feature

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration error if any porch or sync parameter is < 1, if H_TOTAL > 2^CORDW, or if V_TOTAL > 2^CORDW.
- Reset (async, while rst_n=0):
  - sx = H_TOTAL-1, sy = V_TOTAL-1.
  - de = 0, hsync = ~HS_POL, vsync = ~VS_POL.
  - line, frame, vblank, anim_tick = 0; frame_cnt = 0.
- Advance (each clk edge with en=1):
  - sx increments; at H_TOTAL-1 it wraps to 0 and sy increments.
  - When sy is also at V_TOTAL-1, sy wraps to 0.
  - The first enabled edge after reset therefore lands on (0,0) with frame=1 and line=1.
- All outputs are registered and mutually aligned: in any cycle, de, hsync, vsync and the strobes describe the pixel (sx,sy). Flags are computed from the next-state coordinates, so there is no extra latency.
- de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
- hsync is active for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC, over whole lines (changes at sx==0).
- Strobes:
  - Each strobe is high for exactly one clk cycle, following the enabled edge that entered the position.
  - Any edge with en=0 clears all strobes and holds every other output.
- frame_cnt increments on each wrap to (0,0), but not on the first landing after reset. It wraps from 2^FRAME_W-1 to 0.
- Reset asserted mid-frame returns all outputs to reset values immediately. After release, the sequence restarts at (0,0).

Optional Feature:
- Macro: VTG_ANIM_TICK_EN.
- When defined:
  - Adds parameter ANIM_DIV (default 1, legal >= 1) and an internal divide counter.
  - anim_tick pulses together with vblank on every ANIM_DIV-th vblank; the first pulse is on the ANIM_DIV-th vblank after reset.
  - The divide counter resets to 0.
- When undefined: anim_tick is tied to 0 and no counter is built.

Decomposition:
- Package video_timing_pkg holds:
  - constant sets for 640x480@60 and 1280x720@60 (active, porches, syncs, polarities);
  - a function returning the total from active/fp/sync/bp.
- Sub-module vtg_axis_counter, instantiated once per axis:
  - parameters ACTIVE, FP, SYNC, BP, POL, W;
  - inputs step and wrap-enable;
  - outputs the count, active flag, sync flag, at-last flag and entered-zero flag.

Test Plan:
- Defaults, release reset, en=1: first edge gives sx=0, sy=0, de=1, frame=1, line=1. sx reaches 799 and wraps to 0, sy goes to 1 with line=1. Frame period is 420000 cycles.
- Sync timing: hsync low exactly for sx 656..751 (96 cycles per line); vsync low for sy 490..491 only; de high for 307200 cycles per frame; vblank at (0,480) once per frame.
- en toggling 1-of-2: identical coordinate sequence at 840000 cycles per frame; each strobe is high for 1 clk only; outputs hold during en=0 cycles.
- Reset pulse at (300,200) mid-frame: outputs go to reset values without a clock edge. After release, the first enabled edge gives (0,0) with frame=1, and frame_cnt is 0.
- Small parameters H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=1, FRAME_W=2: H_TOTAL=7, V_TOTAL=5; hsync high at sx=5; frame_cnt counts 0,1,2,3,0 over five frames.
- With VTG_ANIM_TICK_EN and ANIM_DIV=3: anim_tick coincides with vblank on frames 3, 6 and 9 only. Without the macro, anim_tick stays 0.
